// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and the
// baud divisor calculation (rounded to the nearest whole clock count).
package uart_rx_fifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// Ports:
//   clk, resetn          clock, async active-low reset
//   push, wr_data        write request and data (ignored when full unless popping)
//   pop                  read request (ignored when empty)
//   rd_data              head entry, 0 when empty
//   count, full, empty   occupancy status
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;

    // A push into a full FIFO is still taken when the head leaves in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
        else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver with a receive FIFO and sticky error flags.
// Ports:
//   clk, resetn          system clock, async active-low reset
//   rxd                  raw serial line (asynchronous, idles high)
//   rd_valid/rd_ready    pop handshake, rd_data is the head byte
//   rx_count             bytes buffered
//   overrun, frame_err   sticky error flags, cleared by clr_err pulse
//
// state   | meaning
// IDLE    | line idle, waiting for a low level
// START   | half-bit wait, confirm start bit still low
// DATA    | sample 8 data bits, one per bit period, LSB first
// STOP    | sample stop bit; high pushes byte, low flags framing error
// BREAK   | line held low after a bad stop bit, wait for it to go high
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            rxd,
    output logic                            rd_valid,
    input  logic                            rd_ready,
    output logic [7:0]                      rd_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count,
    output logic                            overrun,
    output logic                            frame_err,
    input  logic                            clr_err
);
    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] FULL_BIT = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(DIV / 2 - 1);

    rx_state_e     state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          overrun_q, overrun_d;
    logic          frame_err_q, frame_err_d;
    logic          rxd_s, push, frame_set, overrun_set, pop;
    logic          fifo_full, fifo_empty;

    assign sync_d = {sync_q[0], rxd};
    assign rxd_s  = sync_q[1];

    // Counter is a down-counter: the phase event fires when it reaches zero,
    // so loading N-1 on state entry gives an event N cycles later.
    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
        idx_d     = idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!rxd_s) begin
                    state_d = ST_START;
                    cnt_d   = HALF_BIT;
                end
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    if (rxd_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = FULL_BIT;
                        idx_d   = 3'd0;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    // Shift in from the top: after 8 samples bit 0 holds the first bit.
                    shift_d = {rxd_s, shift_q[7:1]};
                    cnt_d   = FULL_BIT;
                    if (idx_q == 3'd7) state_d = ST_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    if (rxd_s) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rxd_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pop         = rd_valid & rd_ready;
    assign overrun_set = push & fifo_full & ~pop;

    // Set events take priority over a coincident clear.
    assign overrun_d   = (overrun_q & ~clr_err) | overrun_set;
    assign frame_err_d = (frame_err_q & ~clr_err) | frame_set;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            sync_q      <= 2'b11;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (push),
        .wr_data (shift_q),
        .pop     (pop),
        .rd_data (rd_data),
        .count   (rx_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rd_valid  = ~fifo_empty;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 100000;
    localparam int DEPTH  = 4;
    localparam int BITLEN = 10;

    logic       clk = 1'b0;
    logic       resetn, rxd, rd_ready, clr_err;
    logic       rd_valid, overrun, frame_err;
    logic [7:0] rd_data;
    logic [2:0] rx_count;

    int total = 0;
    int bad   = 0;

    logic [7:0] model_q [$];
    bit         exp_ovr = 1'b0;
    bit         exp_fe  = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rxd       (rxd),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rx_count  (rx_count),
        .overrun   (overrun),
        .frame_err (frame_err),
        .clr_err   (clr_err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check_val({tag, "_count"}, 32'(rx_count), 32'(model_q.size()));
        check_val({tag, "_valid"}, 32'(rd_valid), 32'(model_q.size() != 0));
        check_val({tag, "_ovr"}, 32'(overrun), 32'(exp_ovr));
        check_val({tag, "_fe"}, 32'(frame_err), 32'(exp_fe));
        if (model_q.size() != 0) check_val({tag, "_head"}, 32'(rd_data), 32'(model_q[0]));
        else                     check_val({tag, "_head0"}, 32'(rd_data), 32'h0);
    endtask

    // One complete frame: start, 8 data bits LSB first, stop. Optional pulses
    // of rd_ready / clr_err are aligned with the cycle the receiver samples stop.
    task automatic send_frame(input logic [7:0] b, input bit stop, input bit rdy_at_stop,
                              input bit clr_at_stop, input bit chk_edge);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 9; i++) begin
            rxd = bits[i];
            tick(BITLEN);
        end
        rxd = stop;
        tick(7);
        if (chk_edge) check_val("pre_push_valid", 32'(rd_valid), 32'h0);
        if (rdy_at_stop && model_q.size() != 0)
            check_val("stop_pop_head", 32'(rd_data), 32'(model_q[0]));
        rd_ready = rdy_at_stop;
        clr_err  = clr_at_stop;
        tick(1);
        rd_ready = 1'b0;
        clr_err  = 1'b0;
        if (chk_edge) check_val("post_push_valid", 32'(rd_valid), 32'h1);
        if (clr_at_stop) begin
            exp_ovr = 1'b0;
            exp_fe  = 1'b0;
        end
        if (rdy_at_stop && model_q.size() != 0) void'(model_q.pop_front());
        if (stop) begin
            if (model_q.size() < DEPTH) model_q.push_back(b);
            else                        exp_ovr = 1'b1;
        end else begin
            exp_fe = 1'b1;
        end
        tick(2);
        rxd = 1'b1;
    endtask

    task automatic pop_one(input string tag);
        if (model_q.size() != 0) begin
            check_val({tag, "_pvalid"}, 32'(rd_valid), 32'h1);
            check_val({tag, "_pdata"}, 32'(rd_data), 32'(model_q[0]));
            void'(model_q.pop_front());
        end
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
    endtask

    task automatic clear_err();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        exp_ovr = 1'b0;
        exp_fe  = 1'b0;
    endtask

    initial begin
        resetn   = 1'b0;
        rxd      = 1'b1;
        rd_ready = 1'b0;
        clr_err  = 1'b0;
        tick(3);
        check_state("reset");
        resetn = 1'b1;
        tick(5);

        // single byte, push timing relative to stop sample
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(3);
        check_state("t1");
        pop_one("t1");
        check_state("t1_empty");

        // short low glitch must not start a frame
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(20);
        check_state("t2");
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(4);
        check_state("t2_after");
        pop_one("t2");

        // framing error, clear, then good byte
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(6);
        check_state("t3_fe");
        clear_err();
        check_state("t3_clr");
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(4);
        check_state("t3_55");
        pop_one("t3");

        // overflow
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            tick(4);
        end
        check_state("t4_full");
        for (int i = 0; i < 4; i++) pop_one("t4");
        check_state("t4_drain");
        clear_err();
        for (int i = 0; i < 4; i++) begin
            send_frame(8'h11 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            tick(4);
        end
        send_frame(8'h15, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(4);
        check_state("t4_popfull");
        for (int i = 0; i < 4; i++) pop_one("t4b");

        // reset mid-frame
        send_frame(8'h21, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(4);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(4);
        check_state("t5_pre");
        rxd = 1'b0;
        tick(2 * BITLEN + 5);
        resetn = 1'b0;
        #1;
        model_q.delete();
        exp_ovr = 1'b0;
        exp_fe  = 1'b0;
        check_state("t5_rst");
        rxd = 1'b1;
        tick(3);
        resetn = 1'b1;
        tick(5);
        send_frame(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(4);
        check_state("t5_7e");
        pop_one("t5");

        // clear coincident with overrun set
        for (int i = 0; i < 4; i++) begin
            send_frame(8'h31 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            tick(4);
        end
        send_frame(8'h35, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(4);
        check_state("t6");
        clear_err();
        check_state("t6_clr");
        for (int i = 0; i < 4; i++) pop_one("t6");

        // randomized traffic
        for (int n = 0; n < 25; n++) begin
            logic [7:0] b;
            bit         stop, rdy, clr;
            int         npop;
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 5) != 0);
            rdy  = ($urandom_range(0, 3) == 0);
            clr  = ($urandom_range(0, 5) == 0);
            send_frame(b, stop, rdy, clr, 1'b0);
            tick(4 + $urandom_range(0, 6));
            check_state("rnd");
            npop = $urandom_range(0, 2);
            for (int k = 0; k < npop; k++) pop_one("rnd");
            if ($urandom_range(0, 4) == 0) clear_err();
        end
        while (model_q.size() != 0) pop_one("final");
        check_state("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
